psum_accum: RTL and testbench

//  Downstream consumer of the MAC column's partial sums. Accumulates a stream of signed psums over
//  NUM_PASS passes (one pass per kernel tap) into a DEPTH-entry register file, one entry per output

---
 rtl/psum_accum_pkg.sv | 30 +++
 rtl/psum_sat_relu.sv | 25 ++
 rtl/psum_accum.sv | 122 ++++++++++++
 tb/tb_psum_accum.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_accum_pkg.sv
// Shared definitions for the partial-sum accumulator: default widths,
// FSM state encoding and a saturation helper at the default widths.
package psum_accum_pkg;

  localparam int PSUM_BW_DEF = 16;
  localparam int ACC_BW_DEF  = 20;
  localparam int DEPTH_DEF   = 16;
  localparam int PASS_BW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FINAL = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  // Clamp an accumulator value into the signed psum range.
  function automatic logic signed [PSUM_BW_DEF-1:0] sat_psum(
    input logic signed [ACC_BW_DEF-1:0] acc
  );
    logic signed [ACC_BW_DEF-1:0] hi;
    logic signed [ACC_BW_DEF-1:0] lo;
    hi = ACC_BW_DEF'((longint'(1) <<< (PSUM_BW_DEF - 1)) - 1);
    lo = ~hi;
    if (acc > hi)      return hi[PSUM_BW_DEF-1:0];
    else if (acc < lo) return lo[PSUM_BW_DEF-1:0];
    else               return acc[PSUM_BW_DEF-1:0];
  endfunction

endpackage

// File: rtl/psum_sat_relu.sv
// Output conditioning: saturate a wide accumulator to psum width, then
// optionally clamp negative results to zero.
module psum_sat_relu #(
  parameter int psum_bw = 16,
  parameter int acc_bw  = 20
) (
  input  logic signed [acc_bw-1:0]  acc,
  input  logic                      relu_en,
  output logic signed [psum_bw-1:0] res
);

  localparam logic signed [acc_bw-1:0] MAXV = acc_bw'((longint'(1) <<< (psum_bw - 1)) - 1);
  localparam logic signed [acc_bw-1:0] MINV = ~MAXV;

  logic signed [psum_bw-1:0] sat;

  always_comb begin
    if (acc > MAXV)      sat = MAXV[psum_bw-1:0];
    else if (acc < MINV) sat = MINV[psum_bw-1:0];
    else                 sat = acc[psum_bw-1:0];
    // ReLU acts on the already-saturated value.
    res = (relu_en && sat[psum_bw-1]) ? '0 : sat;
  end

endmodule

// File: rtl/psum_accum.sv
// Multi-pass partial-sum accumulator for one MAC column: sums NUM_PASS passes
// per output position and streams the saturated (optionally ReLU'd) results.
//
// Handshakes: a beat moves on a port only in a cycle where valid & ready are
// both 1 at the rising edge; out_valid never retracts and out_data holds
// while out_ready is low.
module psum_accum
  import psum_accum_pkg::*;
#(
  parameter int psum_bw = PSUM_BW_DEF,
  parameter int acc_bw  = ACC_BW_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int pass_bw = PASS_BW_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [pass_bw-1:0]        num_pass,
  input  logic                      relu_en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [psum_bw-1:0] in_psum,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [psum_bw-1:0] out_data,
  output logic                      busy,
  output logic                      done,
  output state_t                    state_dbg
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t                    state, state_nx;
  logic [AW-1:0]             idx;
  logic [pass_bw-1:0]        pass, k_reg;
  logic                      relu_reg;
  logic signed [acc_bw-1:0]  acc [DEPTH];
  logic signed [acc_bw-1:0]  psum_ext, acc_base, sum;
  logic signed [psum_bw-1:0] result;
  logic                      in_xfer, out_xfer, last_idx, last_accum_pass;

  assign psum_ext        = acc_bw'(in_psum);
  // Pass 0 overwrites, so stale contents from an aborted job never leak in.
  assign acc_base        = (pass == '0) ? '0 : acc[idx];
  assign sum             = acc_base + psum_ext;
  assign in_xfer         = in_valid & in_ready;
  assign out_xfer        = out_valid & out_ready;
  assign last_idx        = (idx == LAST_IDX);
  assign last_accum_pass = (pass == k_reg - pass_bw'(2));
  assign busy            = (state != ST_IDLE);
  assign state_dbg       = state;

  psum_sat_relu #(.psum_bw(psum_bw), .acc_bw(acc_bw)) u_sat_relu (
    .acc     (sum),
    .relu_en (relu_reg),
    .res     (result)
  );

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = (num_pass > pass_bw'(1)) ? ST_ACCUM : ST_FINAL;
      end
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last_idx && last_accum_pass) state_nx = ST_FINAL;
      end
      ST_FINAL: begin
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready && last_idx) state_nx = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (out_xfer) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      pass      <= '0;
      k_reg     <= pass_bw'(1);
      relu_reg  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= (state == ST_FLUSH) && out_xfer;
      if (state == ST_IDLE && start) begin
        k_reg    <= (num_pass == '0) ? pass_bw'(1) : num_pass;
        relu_reg <= relu_en;
        idx      <= '0;
        pass     <= '0;
      end else if (in_xfer) begin
        if (last_idx) begin
          idx  <= '0;
          pass <= pass + pass_bw'(1);
        end else begin
          idx <= idx + AW'(1);
        end
      end
      // A new result may load in the same cycle the previous one leaves.
      if (in_xfer && state == ST_FINAL) begin
        out_valid <= 1'b1;
        out_data  <= result;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_xfer && state == ST_ACCUM) acc[idx] <= sum;
  end

endmodule

// File: tb/tb_psum_accum.sv
// Self-checking bench for psum_accum: directed and random jobs against a
// per-entry arithmetic model of the multi-pass sum, saturation and ReLU.
module tb_psum_accum;
  import psum_accum_pkg::*;

  localparam int PW = 16;
  localparam int AB = 20;
  localparam int DP = 16;
  localparam int PB = 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 start = 1'b0;
  logic [PB-1:0]        num_pass = '0;
  logic                 relu_en = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [PW-1:0] in_psum = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [PW-1:0] out_data;
  logic                 busy;
  logic                 done;
  state_t               state_dbg;

  psum_accum #(.psum_bw(PW), .acc_bw(AB), .DEPTH(DP), .pass_bw(PB)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_pass  (num_pass),
    .relu_en   (relu_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_psum   (in_psum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int            vectors = 0;
  int            miscompares = 0;
  logic [PW-1:0] exp_q[$];
  int            job_data[$];
  int            rdy_pct = 100;
  bit            busy_exp = 1'b0;
  bit            final_phase = 1'b0;
  bit            prev_stall = 1'b0;
  bit            lat_pend = 1'b0;
  logic [PW-1:0] prev_data = '0;
  int            done_cnt = 0;
  int            out_cnt = 0;
  int            lit_mode = 0;
  int            lit_val = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: sum all passes for one entry, wrap at AB bits, saturate, ReLU.
  function automatic int model_entry(input int k, input int e, input bit relu);
    longint s;
    s = 0;
    for (int p = 0; p < k; p++) s += job_data[p*DP + e];
    s = ((s % 1048576) + 1048576) % 1048576;
    if (s >= 524288) s -= 1048576;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return int'(s);
  endfunction

  function automatic int rand_psum();
    logic signed [PW-1:0] v;
    case ($urandom_range(0, 3))
      0: begin v = PW'($urandom); return int'(v); end
      1: return int'($urandom_range(0, 400)) - 200;
      2: return ($urandom_range(0, 1) == 1) ? 32767 : -32768;
      default: return int'($urandom_range(0, 20000));
    endcase
  endfunction

  // ---------------- sink driver ----------------
  always begin
    @(negedge clk);
    out_ready = ($urandom_range(0, 99) < rdy_pct);
  end

  // ---------------- compare process ----------------
  always begin
    logic [PW-1:0] e;
    @(negedge clk);
    #2;
    if (!reset) begin
      prev_stall = 1'b0;
      lat_pend   = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        chk(exp_q.size() == 0, "done_after_last", exp_q.size(), 0);
        busy_exp = 1'b0;
      end
      if (busy_exp) chk(busy == 1'b1, "busy_high", int'(busy), 1);
      if (final_phase && busy_exp)
        chk(in_ready == (!out_valid || out_ready), "in_ready_rule", int'(in_ready),
            int'(!out_valid || out_ready));
      if (prev_stall) begin
        chk(out_valid == 1'b1, "valid_held", int'(out_valid), 1);
        chk(out_data == prev_data, "data_held", int'(out_data), int'($signed(prev_data)));
      end
      if (lat_pend) chk(out_valid == 1'b1, "latency_1", int'(out_valid), 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_output", int'(out_data), 0);
        end else begin
          e = exp_q.pop_front();
          chk(out_data == e, "out_data", int'(out_data), int'($signed(e)));
          if (lit_mode == 1) chk(int'(out_data) == lit_val, "out_literal", int'(out_data), lit_val);
          if (lit_mode == 2) chk(int'(out_data) == out_cnt - 8, "out_seq", int'(out_data), out_cnt - 8);
          out_cnt++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      lat_pend   = final_phase && in_valid && in_ready;
    end
  end

  // ---------------- job driver ----------------
  // mode: 0 random, 1 idx-8, 2 constant a, 3 pass0=a then b.
  task automatic run_job(input int kin, input bit relu, input int mode, input int a, input int b,
                         input int vpct, input int abort_after, input bit poke_start);
    int k, n, i, tries, budget;
    k = (kin == 0) ? 1 : kin;
    n = k * DP;
    job_data.delete();
    for (int p = 0; p < k; p++)
      for (int e = 0; e < DP; e++)
        case (mode)
          0:       job_data.push_back(rand_psum());
          1:       job_data.push_back(e - 8);
          2:       job_data.push_back(a);
          default: job_data.push_back((p == 0) ? a : b);
        endcase
    out_cnt  = 0;
    done_cnt = 0;
    if (abort_after < 0)
      for (int e = 0; e < DP; e++) exp_q.push_back(PW'(model_entry(k, e, relu)));

    @(negedge clk);
    start    = 1'b1;
    num_pass = PB'(kin);
    relu_en  = relu;
    @(negedge clk);
    start    = 1'b0;
    relu_en  = ~relu;
    num_pass = PB'($urandom_range(0, 255));
    busy_exp = 1'b1;

    i = 0;
    tries = 0;
    while (i < n && (abort_after < 0 || i < abort_after)) begin
      if (tries > 0) @(negedge clk);
      in_valid    = ($urandom_range(0, 99) < vpct);
      in_psum     = PW'(job_data[i]);
      start       = poke_start && (tries == 3);
      final_phase = (i >= (k - 1) * DP);
      #1;
      if (in_valid && in_ready) i++;
      tries++;
      if (tries > 20000) begin
        chk(1'b0, "input_timeout", i, n);
        break;
      end
    end
    @(negedge clk);
    in_valid    = 1'b0;
    start       = 1'b0;
    final_phase = 1'b0;

    if (abort_after >= 0) begin
      reset = 1'b0;
      #1;
      chk(out_valid == 1'b0, "abort_out_valid", int'(out_valid), 0);
      chk(in_ready == 1'b0, "abort_in_ready", int'(in_ready), 0);
      chk(busy == 1'b0, "abort_busy", int'(busy), 0);
      chk(out_data == '0, "abort_out_data", int'(out_data), 0);
      exp_q.delete();
      busy_exp = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      return;
    end

    budget = 0;
    while (done_cnt == 0 && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    chk(done_cnt == 1, "done_seen", done_cnt, 1);
    busy_exp = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk(done_cnt == 1, "done_once", done_cnt, 1);
    chk(exp_q.size() == 0, "outputs_drained", exp_q.size(), 0);
    chk(out_cnt == DP, "output_count", out_cnt, DP);
    chk(busy == 1'b0, "idle_after_done", int'(busy), 0);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk(out_valid == 1'b0, "rst_out_valid", int'(out_valid), 0);
    chk(in_ready == 1'b0, "rst_in_ready", int'(in_ready), 0);
    chk(busy == 1'b0, "rst_busy", int'(busy), 0);
    chk(done == 1'b0, "rst_done", int'(done), 0);
    chk(out_data == '0, "rst_out_data", int'(out_data), 0);
    reset = 1'b1;
    @(negedge clk);

    rdy_pct = 100;
    lit_mode = 2;                run_job(1, 1'b0, 1, 0, 0, 100, -1, 1'b0);
    lit_mode = 1; lit_val = 300;    run_job(3, 1'b0, 2, 100, 0, 100, -1, 1'b0);
    lit_val = 32767;             run_job(4, 1'b0, 2, 32767, 0, 100, -1, 1'b0);
    lit_val = -32768;            run_job(4, 1'b0, 2, -32768, 0, 100, -1, 1'b0);
    lit_val = 0;                 run_job(2, 1'b1, 3, -5, 3, 100, -1, 1'b0);
    lit_val = 2;                 run_job(2, 1'b1, 3, 5, -3, 100, -1, 1'b0);

    lit_mode = 0; rdy_pct = 30;  run_job(2, 1'b0, 0, 0, 0, 70, -1, 1'b1);
    rdy_pct = 100;               run_job(3, 1'b0, 0, 0, 0, 100, 20, 1'b0);
    lit_mode = 1; lit_val = 7;   run_job(1, 1'b0, 2, 7, 0, 100, -1, 1'b0);

    lit_mode = 0;
    for (int j = 0; j < 10; j++) begin
      rdy_pct = $urandom_range(30, 100);
      run_job($urandom_range(0, 5), 1'($urandom_range(0, 1)), 0, 0, 0,
              $urandom_range(50, 100), -1, 1'(j % 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
